axi4_master_bridge: RTL

Single-outstanding AXI4 master that turns a simple cache-side request port into AXI4 INCR burst transactions. It sits between the core's I/D-cache refill/writeback logic and the AXI4 memory slave. It drives the AR/R channels for reads and the AW/W/B channels for writes. It streams read beats out to the client and pulls write beats in from the client.

---
 rtl/axi4_master_bridge.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/axi4_master_bridge.sv
// Single-outstanding AXI4 master: converts a cache-side request port into one INCR burst at a
// time, streaming read beats to the client and pulling write beats from it.
module axi4_master_bridge #(
  parameter logic [3:0] AXI_ID  = 4'h0,
  parameter logic [7:0] MAX_LEN = 8'd7
) (
  input  logic        aclk,
  input  logic        areset,
  // client request port
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [7:0]  req_len,
  // client write beats
  input  logic        wd_valid,
  output logic        wd_ready,
  input  logic [63:0] wd_data,
  input  logic [7:0]  wd_strb,
  // client read beats
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [63:0] rd_data,
  output logic        rd_last,
  // completion
  output logic        done,
  output logic        err,
  // AR channel
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [3:0]  arid,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // R channel
  input  logic [63:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic [3:0]  rid,
  input  logic        rvalid,
  output logic        rready,
  // AW channel
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [3:0]  awid,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  // W channel
  output logic [63:0] wdata,
  output logic [7:0]  wstrb,
  output logic        wlast,
  output logic [3:0]  wid,
  output logic        wvalid,
  input  logic        wready,
  // B channel
  input  logic [1:0]  bresp,
  input  logic [3:0]  bid,
  input  logic        bvalid,
  output logic        bready
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StRaddr = 3'd1;
  localparam logic [2:0] StRdata = 3'd2;
  localparam logic [2:0] StWrite = 3'd3;
  localparam logic [2:0] StWresp = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  rcnt_q, rcnt_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        err_q, err_d;
  // Low through reset and for the first cycle after it, so req_ready stays low meanwhile.
  logic        live_q;

  logic ar_hs, r_hs, aw_hs, w_hs, w_last_beat;

  // Only one transaction is ever outstanding, so the response IDs carry no information.
  logic unused_ids;
  assign unused_ids = ^{rid, bid};

  assign ar_hs       = (state_q == StRaddr) && arready;
  assign r_hs        = (state_q == StRdata) && rvalid && rd_ready;
  assign aw_hs       = (state_q == StWrite) && !aw_done_q && awready;
  assign w_hs        = (state_q == StWrite) && !w_done_q && wd_valid && wready;
  assign w_last_beat = (wcnt_q == len_q);

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= StIdle;
      addr_q    <= 32'h0;
      len_q     <= 8'h0;
      rcnt_q    <= 8'h0;
      wcnt_q    <= 8'h0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= 1'b0;
      live_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      rcnt_q    <= rcnt_d;
      wcnt_q    <= wcnt_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      err_q     <= err_d;
      live_q    <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    rcnt_d    = rcnt_q;
    wcnt_d    = wcnt_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    err_d     = err_q;
    unique case (state_q)
      StIdle: begin
        if (live_q && req_valid) begin
          addr_d    = req_addr;
          len_d     = (req_len > MAX_LEN) ? MAX_LEN : req_len;
          rcnt_d    = 8'h0;
          wcnt_d    = 8'h0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          err_d     = 1'b0;
          state_d   = req_write ? StWrite : StRaddr;
        end
      end
      StRaddr: begin
        if (ar_hs) begin
          state_d = StRdata;
        end
      end
      StRdata: begin
        if (r_hs) begin
          if (rcnt_q != 8'hff) begin
            rcnt_d = rcnt_q + 8'd1;
          end
          if (rresp != 2'b00) begin
            err_d = 1'b1;
          end
          if (rlast) begin
            if (rcnt_q != len_q) begin
              err_d = 1'b1;
            end
            state_d = StDone;
          end else if (rcnt_q >= len_q) begin
            // Slave overran the requested length; keep draining until rlast.
            err_d = 1'b1;
          end
        end
      end
      StWrite: begin
        if (aw_hs) begin
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wcnt_d = wcnt_q + 8'd1;
          if (w_last_beat) begin
            w_done_d = 1'b1;
          end
        end
        if ((aw_done_q || aw_hs) && (w_done_q || (w_hs && w_last_beat))) begin
          state_d = StWresp;
        end
      end
      StWresp: begin
        if (bvalid) begin
          if (bresp != 2'b00) begin
            err_d = 1'b1;
          end
          state_d = StDone;
        end
      end
      StDone: begin
        err_d   = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    req_ready = live_q && (state_q == StIdle);

    arvalid = (state_q == StRaddr);
    araddr  = addr_q;
    arlen   = len_q;
    arid    = AXI_ID;

    rready   = (state_q == StRdata) && rd_ready;
    rd_valid = (state_q == StRdata) && rvalid;
    rd_data  = rdata;
    rd_last  = (state_q == StRdata) && rlast;

    awvalid = (state_q == StWrite) && !aw_done_q;
    awaddr  = addr_q;
    awlen   = len_q;
    awid    = AXI_ID;

    wvalid   = (state_q == StWrite) && !w_done_q && wd_valid;
    wd_ready = (state_q == StWrite) && !w_done_q && wready;
    wdata    = wd_data;
    wstrb    = wd_strb;
    wlast    = w_last_beat;
    wid      = AXI_ID;

    bready = (state_q == StWresp);
    done   = (state_q == StDone);
    err    = err_q;
  end

  assign arsize  = 3'd3;
  assign awsize  = 3'd3;
  assign arburst = 2'b01;
  assign awburst = 2'b01;
  assign arlock  = 1'b0;
  assign awlock  = 1'b0;
  assign arcache = 4'h0;
  assign awcache = 4'h0;
  assign arprot  = 3'h0;
  assign awprot  = 3'h0;

endmodule
